lcd_pattern_writer: RTL and testbench
=====================================

// Module: lcd_pattern_writer
// PURPOSE
//  Parametrised test-pattern frame generator feeding the SDRAM write FIFO.
//  Periodically writes one full H_DISP x V_DISP frame in one of four pattern modes.
//  Honours FIFO backpressure and queues one missed frame trigger.
//  Sits between SDRAM controller write port and LCD read path, replacing fixed solid-colour test writers.
// PARAMETERS
//  DATA_W      16          wr_data width (>=16); pixel in [15:0] RGB565, upper bits 0
//  H_DISP      800         pixels per line
//  V_DISP      480         lines per frame
//  INTERVAL    50_000_000  clk_50m cycles between frame triggers (>=2)
//  NUM_COLORS  3           palette entries used, 1..8
//  BAR_W       H_DISP/8    pixels per colour bar (mode 1), >=1
//  CHK_SHIFT   5           checker square = 2**CHK_SHIFT pixels (mode 2)
// PORTS
//  clk_50m          in   1       system clock
//  rst              in   1       async reset, active high
//  sdram_init_done  in   1       SDRAM ready; low holds block idle
//  mode             in   2       0 solid, 1 colour bars, 2 checker, 3 gradient
//  wr_full          in   1       FIFO cannot accept a word this cycle
//  wr_en            out  1       FIFO write strobe; valid with wr_data same cycle
//  wr_data          out  DATA_W  pixel word
//  frame_busy       out  1       high while a frame is being written
//  frame_done       out  1       1-cycle pulse after last pixel accepted
//  overrun          out  1       sticky: trigger dropped (cleared only by rst)
//  color_idx        out  3       current palette index
// BEHAVIOUR
//  Reset (async): all outputs 0, counters 0, FSM IDLE, pending 0.
//  Palette (RGB565): 0 F800, 1 07E0, 2 001F, 3 FFFF, 4 0000, 5 FFE0, 6 07FF, 7 F81F.
//  Interval counter: runs only while sdram_init_done=1; counts 0..INTERVAL-1, wraps to 0.
//    Wrap cycle = trigger tick; each tick advances color_idx (NUM_COLORS-1 -> 0).
//  FSM:
//    IDLE   -> WRITE on tick (or pending=1). Latches mode, clears x/y, clears pending.
//    WRITE  -> DONE when last pixel (x=H_DISP-1, y=V_DISP-1) is written.
//    DONE   -> IDLE next cycle; frame_done=1 for exactly this cycle.
//  Write rule: in WRITE, wr_en=1 on every cycle with wr_full=0. wr_data is registered with wr_en;
//    with wr_full=0 continuously, the first wr_en is 1 cycle after the trigger and
//    frame length = H_DISP*V_DISP consecutive strobes.
//  wr_full=1: wr_en=0, x/y hold, no word lost or duplicated.
//  Pixel position: x increments per accepted word; at H_DISP-1 wraps to 0 and y increments.
//  Pattern (mode latched at frame start; color_idx fixed for the frame):
//    0: palette[color_idx]
//    1: palette[(color_idx+bar) mod NUM_COLORS]. bar increments every BAR_W pixels (mod NUM_COLORS)
//       and resets to 0 each line. No divider: uses a bar-width counter.
//    2: x[CHK_SHIFT]^y[CHK_SHIFT] ? palette[color_idx] : 0000
//    3: {x[4:0], y[5:0], frame_cnt[4:0]}; frame_cnt = 5-bit count of completed frames
//  frame_busy=1 in WRITE and DONE.
//  Tick while WRITE/DONE: pending=1, and the next frame starts the cycle after DONE->IDLE.
//    Tick while pending=1 already: dropped, overrun<=1.
//  sdram_init_done falling in any state: abort to IDLE next cycle; wr_en=0, pending=0,
//    interval counter=0. No frame_done. color_idx holds.
//  Widths: x/y/bar counters sized $clog2 of their range; no overflow beyond the stated wraps.
// TESTING (H_DISP=8 V_DISP=4 INTERVAL=100 NUM_COLORS=3 BAR_W=2 CHK_SHIFT=1 unless stated)
//  1 mode0, wr_full=0: tick at cycle 99 -> exactly 32 wr_en, all 16'h07E0 (idx 1),
//    then frame_done pulse; next frame 16'h001F, then 16'hF800.
//  2 mode1: line words = 07E0,07E0,001F,001F,F800,F800,07E0,07E0, repeated on each of 4 lines.
//  3 mode0, wr_full toggled randomly 50%: still exactly 32 words, no repeats or gaps
//    (scoreboard compares against x/y model).
//  4 INTERVAL=20 (frame 32 > interval): pending starts frames back-to-back; third queued tick sets
//    overrun=1, which stays 1 until rst.
//  5 drop sdram_init_done at word 10 -> wr_en=0 next cycle, frame_busy=0, no frame_done;
//    re-raise -> fresh full frame from x=y=0.
//  6 assert rst mid-frame -> all outputs 0 immediately (async); after release, first tick writes
//    palette idx 1.

Source files
------------

// File: rtl/lcd_pattern_writer.sv
// lcd_pattern_writer
//   Periodic test-pattern frame generator that feeds the SDRAM write FIFO.
//   Every INTERVAL cycles (while SDRAM is ready) it writes one H_DISP x V_DISP
//   frame in one of four pattern modes, honouring FIFO backpressure. One
//   trigger that arrives mid-frame is queued; a further one is dropped and
//   flagged on the sticky overrun output.
//
// Ports
//   clk_50m          in   system clock
//   rst              in   asynchronous reset, active high
//   sdram_init_done  in   SDRAM ready; low aborts/holds the block idle
//   mode[1:0]        in   0 solid, 1 colour bars, 2 checker, 3 gradient
//   wr_full          in   FIFO cannot accept a word this cycle
//   wr_en            out  FIFO write strobe, qualifies wr_data
//   wr_data          out  pixel word, RGB565 in [15:0], upper bits zero
//   frame_busy       out  high while a frame is in progress (WRITE/DONE)
//   frame_done       out  one-cycle pulse in the DONE state
//   overrun          out  sticky flag: a frame trigger was dropped
//   color_idx[2:0]   out  current palette index
module lcd_pattern_writer #(
  parameter int DATA_W     = 16,
  parameter int H_DISP     = 800,
  parameter int V_DISP     = 480,
  parameter int INTERVAL   = 50_000_000,
  parameter int NUM_COLORS = 3,
  parameter int BAR_W      = H_DISP / 8,
  parameter int CHK_SHIFT  = 5
) (
  input  logic              clk_50m,
  input  logic              rst,
  input  logic              sdram_init_done,
  input  logic [1:0]        mode,
  input  logic              wr_full,
  output logic              wr_en,
  output logic [DATA_W-1:0] wr_data,
  output logic              frame_busy,
  output logic              frame_done,
  output logic              overrun,
  output logic [2:0]        color_idx
);

  localparam int X_W = (H_DISP   > 1) ? $clog2(H_DISP)   : 1;
  localparam int Y_W = (V_DISP   > 1) ? $clog2(V_DISP)   : 1;
  localparam int B_W = (BAR_W    > 1) ? $clog2(BAR_W)    : 1;
  localparam int C_W = (INTERVAL > 1) ? $clog2(INTERVAL) : 1;

  localparam logic [X_W-1:0] X_LAST  = X_W'(H_DISP - 1);
  localparam logic [Y_W-1:0] Y_LAST  = Y_W'(V_DISP - 1);
  localparam logic [B_W-1:0] B_LAST  = B_W'(BAR_W - 1);
  localparam logic [C_W-1:0] C_LAST  = C_W'(INTERVAL - 1);
  localparam logic [2:0]     NC_LAST = 3'(NUM_COLORS - 1);

  typedef enum logic [1:0] {S_IDLE, S_WRITE, S_DONE} state_t;

  function automatic logic [15:0] palette(input logic [2:0] idx);
    logic [15:0] c;
    case (idx)
      3'd0:    c = 16'hF800;
      3'd1:    c = 16'h07E0;
      3'd2:    c = 16'h001F;
      3'd3:    c = 16'hFFFF;
      3'd4:    c = 16'h0000;
      3'd5:    c = 16'hFFE0;
      3'd6:    c = 16'h07FF;
      default: c = 16'hF81F;
    endcase
    return c;
  endfunction

  // (a + b) mod NUM_COLORS for a, b < NUM_COLORS: one conditional subtract.
  function automatic logic [2:0] add_mod(input logic [2:0] a, input logic [2:0] b);
    logic [3:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s >= 4'(NUM_COLORS)) s = s - 4'(NUM_COLORS);
    return s[2:0];
  endfunction

  function automatic logic [15:0] pixel(input logic [1:0]     m,
                                        input logic [2:0]     col,
                                        input logic [X_W-1:0] px,
                                        input logic [Y_W-1:0] py,
                                        input logic [2:0]     bar,
                                        input logic [4:0]     fcnt);
    logic [31:0] xw;
    logic [31:0] yw;
    logic [15:0] p;
    // Widen so the fixed bit selects stay legal for tiny displays.
    xw = 32'(px);
    yw = 32'(py);
    case (m)
      2'd0:    p = palette(col);
      2'd1:    p = palette(add_mod(col, bar));
      2'd2:    p = (xw[CHK_SHIFT] ^ yw[CHK_SHIFT]) ? palette(col) : 16'h0000;
      default: p = {xw[4:0], yw[5:0], fcnt};
    endcase
    return p;
  endfunction

  state_t            state_q, state_d;
  logic [C_W-1:0]    cnt_q, cnt_d;
  logic [2:0]        color_q, color_d;
  logic [2:0]        fcolor_q, fcolor_d;
  logic [1:0]        mode_q, mode_d;
  logic [X_W-1:0]    x_q, x_d;
  logic [Y_W-1:0]    y_q, y_d;
  logic [B_W-1:0]    barcnt_q, barcnt_d;
  logic [2:0]        bar_q, bar_d;
  logic [4:0]        fcnt_q, fcnt_d;
  logic              pending_q, pending_d;
  logic              overrun_q, overrun_d;
  logic              wr_en_q, wr_en_d;
  logic [DATA_W-1:0] wr_data_q, wr_data_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic       tick;
  logic       start;
  logic       active;
  logic       emit;
  logic [2:0] color_next;

  // Values seen by the pixel path this cycle. On the start cycle the frame
  // registers are not loaded yet, so the first pixel is taken from the inputs
  // directly; this puts the first strobe one cycle after the trigger.
  logic [1:0]     cur_mode;
  logic [2:0]     cur_color;
  logic [X_W-1:0] cur_x;
  logic [Y_W-1:0] cur_y;
  logic [B_W-1:0] cur_barcnt;
  logic [2:0]     cur_bar;

  assign tick       = sdram_init_done && (cnt_q == C_LAST);
  assign color_next = tick ? ((color_q == NC_LAST) ? 3'd0 : color_q + 3'd1) : color_q;
  assign start      = sdram_init_done && (state_q == S_IDLE) && (tick || pending_q);
  assign active     = start || (sdram_init_done && (state_q == S_WRITE));
  assign emit       = active && !wr_full;

  assign cur_mode   = start ? mode       : mode_q;
  assign cur_color  = start ? color_next : fcolor_q;
  assign cur_x      = start ? '0         : x_q;
  assign cur_y      = start ? '0         : y_q;
  assign cur_barcnt = start ? '0         : barcnt_q;
  assign cur_bar    = start ? 3'd0       : bar_q;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    color_d   = color_next;
    fcolor_d  = fcolor_q;
    mode_d    = mode_q;
    x_d       = x_q;
    y_d       = y_q;
    barcnt_d  = barcnt_q;
    bar_d     = bar_q;
    fcnt_d    = fcnt_q;
    pending_d = pending_q;
    overrun_d = overrun_q;
    wr_en_d   = 1'b0;
    wr_data_d = wr_data_q;
    done_d    = 1'b0;

    if (sdram_init_done) cnt_d = tick ? '0 : cnt_q + C_W'(1);

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d   = S_WRITE;
          mode_d    = mode;
          fcolor_d  = color_next;
          x_d       = '0;
          y_d       = '0;
          barcnt_d  = '0;
          bar_d     = 3'd0;
          // A fresh tick landing on the same cycle a queued one is consumed
          // becomes the new queued trigger.
          pending_d = pending_q && tick;
        end
      end
      S_WRITE, S_DONE: begin
        if (tick) begin
          if (pending_q) overrun_d = 1'b1;
          else           pending_d = 1'b1;
        end
        if (state_q == S_DONE) begin
          state_d = S_IDLE;
          fcnt_d  = fcnt_q + 5'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (emit) begin
      wr_en_d   = 1'b1;
      wr_data_d = DATA_W'(pixel(cur_mode, cur_color, cur_x, cur_y, cur_bar, fcnt_q));
      if (cur_x == X_LAST) begin
        x_d      = '0;
        barcnt_d = '0;
        bar_d    = 3'd0;
        if (cur_y == Y_LAST) begin
          y_d     = '0;
          state_d = S_DONE;
          done_d  = 1'b1;
        end else begin
          y_d = cur_y + Y_W'(1);
        end
      end else begin
        x_d = cur_x + X_W'(1);
        if (cur_barcnt == B_LAST) begin
          barcnt_d = '0;
          bar_d    = (cur_bar == NC_LAST) ? 3'd0 : cur_bar + 3'd1;
        end else begin
          barcnt_d = cur_barcnt + B_W'(1);
        end
      end
    end

    // Losing SDRAM ready abandons the frame without a done pulse.
    if (!sdram_init_done) begin
      state_d   = S_IDLE;
      cnt_d     = '0;
      pending_d = 1'b0;
      wr_en_d   = 1'b0;
      done_d    = 1'b0;
    end

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk_50m or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      color_q   <= 3'd0;
      fcolor_q  <= 3'd0;
      mode_q    <= 2'd0;
      x_q       <= '0;
      y_q       <= '0;
      barcnt_q  <= '0;
      bar_q     <= 3'd0;
      fcnt_q    <= 5'd0;
      pending_q <= 1'b0;
      overrun_q <= 1'b0;
      wr_en_q   <= 1'b0;
      wr_data_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      color_q   <= color_d;
      fcolor_q  <= fcolor_d;
      mode_q    <= mode_d;
      x_q       <= x_d;
      y_q       <= y_d;
      barcnt_q  <= barcnt_d;
      bar_q     <= bar_d;
      fcnt_q    <= fcnt_d;
      pending_q <= pending_d;
      overrun_q <= overrun_d;
      wr_en_q   <= wr_en_d;
      wr_data_q <= wr_data_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign wr_en      = wr_en_q;
  assign wr_data    = wr_data_q;
  assign frame_busy = busy_q;
  assign frame_done = done_q;
  assign overrun    = overrun_q;
  assign color_idx  = color_q;

endmodule

// File: tb/tb_lcd_pattern_writer.sv
// Bench for lcd_pattern_writer: an expected-word queue filled by the stimulus
// and drained by a monitor on every wr_en, plus a second instance with a short
// interval for the queued-trigger / overrun behaviour.
module tb_lcd_pattern_writer;

  localparam int H = 8;
  localparam int V = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        init_done;
  logic [1:0]  mode;
  logic        wr_full;
  logic        wr_en;
  logic [15:0] wr_data;
  logic        frame_busy;
  logic        frame_done;
  logic        overrun;
  logic [2:0]  color_idx;

  logic        init4;
  logic [1:0]  mode4 = 2'd0;
  logic        full4 = 1'b0;
  logic        wr_en4;
  logic [15:0] data4;
  logic        busy4;
  logic        done4;
  logic        ovr4;
  logic [2:0]  cidx4;

  always #5 clk = ~clk;

  lcd_pattern_writer #(.DATA_W(16), .H_DISP(H), .V_DISP(V), .INTERVAL(100),
                       .NUM_COLORS(3), .BAR_W(2), .CHK_SHIFT(1)) dut (
    .clk_50m(clk), .rst(rst), .sdram_init_done(init_done), .mode(mode),
    .wr_full(wr_full), .wr_en(wr_en), .wr_data(wr_data), .frame_busy(frame_busy),
    .frame_done(frame_done), .overrun(overrun), .color_idx(color_idx));

  lcd_pattern_writer #(.DATA_W(16), .H_DISP(H), .V_DISP(V), .INTERVAL(20),
                       .NUM_COLORS(3), .BAR_W(2), .CHK_SHIFT(1)) dut4 (
    .clk_50m(clk), .rst(rst), .sdram_init_done(init4), .mode(mode4),
    .wr_full(full4), .wr_en(wr_en4), .wr_data(data4), .frame_busy(busy4),
    .frame_done(done4), .overrun(ovr4), .color_idx(cidx4));

  int          errors = 0;
  int          checks = 0;
  int          done_cnt = 0;
  bit          stall_en = 1'b0;
  logic [15:0] exp_q[$];
  logic [15:0] mon_e;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] pal(input int i);
    case (i)
      0: return 16'hF800;
      1: return 16'h07E0;
      2: return 16'h001F;
      3: return 16'hFFFF;
      4: return 16'h0000;
      5: return 16'hFFE0;
      6: return 16'h07FF;
      default: return 16'hF81F;
    endcase
  endfunction

  // Reference pixel for modes 0, 2 and 3 (CHK_SHIFT = 1).
  function automatic logic [15:0] gpix(input int m, input int c, input int x,
                                       input int y, input int fc);
    logic [31:0] xx;
    logic [31:0] yy;
    logic [31:0] ff;
    xx = x; yy = y; ff = fc;
    if (m == 0) return pal(c);
    if (m == 2) return (xx[1] ^ yy[1]) ? pal(c) : 16'h0000;
    return {xx[4:0], yy[5:0], ff[4:0]};
  endfunction

  task automatic push_frame(input int m, input int c, input int fc);
    for (int y = 0; y < V; y++)
      for (int x = 0; x < H; x++)
        exp_q.push_back(gpix(m, c, x, y, fc));
  endtask

  task automatic push_solid(input logic [15:0] w);
    for (int i = 0; i < H * V; i++) exp_q.push_back(w);
  endtask

  task automatic push_bars();
    logic [15:0] line [8];
    line = '{16'h07E0, 16'h07E0, 16'h001F, 16'h001F,
             16'hF800, 16'hF800, 16'h07E0, 16'h07E0};
    for (int y = 0; y < V; y++)
      for (int x = 0; x < H; x++) exp_q.push_back(line[x]);
  endtask

  task automatic wait_done(input int prev, input string name);
    for (int k = 0; k < 400 && done_cnt == prev; k++) @(negedge clk);
    chk(name, (done_cnt > prev), 1'b1);
  endtask

  task automatic wait_queue(input int level, input string name);
    for (int k = 0; k < 400 && exp_q.size() > level; k++) begin
      @(negedge clk);
      #1;
    end
    chk(name, exp_q.size(), level);
  endtask

  // Monitor: every strobe must match the head of the expected queue, and the
  // queue must be drained exactly when frame_done pulses.
  always @(negedge clk) begin
    if (wr_en === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_word: got %h expected no write", wr_data);
      end else begin
        mon_e = exp_q.pop_front();
        chk("word", wr_data, mon_e);
      end
      chk("busy_with_wr_en", frame_busy, 1'b1);
    end
    if (frame_done === 1'b1) begin
      chk("queue_empty_at_done", exp_q.size(), 0);
      done_cnt++;
    end
  end

  // Backpressure generator, active only when stall_en is set.
  initial begin
    wr_full = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      wr_full = stall_en ? 1'($urandom_range(0, 1)) : 1'b0;
    end
  end

  initial begin
    int d0;
    rst = 1'b1; init_done = 1'b0; init4 = 1'b0; mode = 2'd0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_wr_en", wr_en, 1'b0);
    chk("rst_wr_data", wr_data, 16'h0000);
    chk("rst_busy", frame_busy, 1'b0);
    chk("rst_done", frame_done, 1'b0);
    chk("rst_overrun", overrun, 1'b0);
    chk("rst_color", color_idx, 3'd0);
    @(posedge clk); #1 rst = 1'b0;

    // Solid frames: idx 1, 2, 0; first strobe right after the cycle-99 tick.
    push_solid(16'h07E0);
    @(posedge clk); #1 init_done = 1'b1;
    repeat (99) @(posedge clk);
    @(negedge clk);
    chk("no_word_before_tick", wr_en, 1'b0);
    @(posedge clk); @(negedge clk);
    chk("first_word_time", wr_en, 1'b1);
    wait_done(0, "frame_a_done");
    chk("color_after_a", color_idx, 3'd1);
    push_solid(16'h001F);
    wait_done(1, "frame_b_done");
    push_solid(16'hF800);
    wait_done(2, "frame_c_done");

    // Colour bars, idx 1.
    mode = 2'd1;
    push_bars();
    wait_done(3, "bars_done");

    // Solid under random backpressure, idx 2.
    mode = 2'd0;
    stall_en = 1'b1;
    push_solid(16'h001F);
    wait_done(4, "stall_solid_done");
    stall_en = 1'b0;

    // Gradient under backpressure: position-coded words expose gaps/repeats.
    mode = 2'd3;
    stall_en = 1'b1;
    push_frame(3, 0, 5);
    wait_done(5, "stall_grad_done");
    stall_en = 1'b0;

    // Checker, idx 1.
    mode = 2'd2;
    push_frame(2, 1, 0);
    wait_done(6, "checker_done");

    // Abort after 10 words, then a fresh frame from x=y=0.
    mode = 2'd3;
    push_frame(3, 2, 7);
    wait_queue(22, "abort_reach_10");
    init_done = 1'b0;
    @(negedge clk);
    chk("abort_wr_en", wr_en, 1'b0);
    chk("abort_busy", frame_busy, 1'b0);
    chk("abort_no_extra", exp_q.size(), 22);
    exp_q.delete();
    d0 = done_cnt;
    repeat (10) @(negedge clk);
    chk("abort_no_done", done_cnt, d0);
    chk("abort_color_hold", color_idx, 3'd2);
    push_frame(3, 0, 7);
    @(posedge clk); #1 init_done = 1'b1;
    wait_done(7, "reraise_done");

    // Async reset mid-frame.
    mode = 2'd0;
    push_solid(16'h07E0);
    wait_queue(27, "rst_reach_5");
    #2 rst = 1'b1;
    #1;
    chk("arst_wr_en", wr_en, 1'b0);
    chk("arst_wr_data", wr_data, 16'h0000);
    chk("arst_busy", frame_busy, 1'b0);
    chk("arst_color", color_idx, 3'd0);
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    push_solid(16'h07E0);
    d0 = done_cnt;
    wait_done(d0, "post_rst_done");
    chk("main_overrun", overrun, 1'b0);

    // Short interval: queued triggers and overrun on the second instance.
    init_done = 1'b0;
    @(posedge clk); #1 init4 = 1'b1;
    for (int k = 1; k <= 330; k++) begin
      @(posedge clk); @(negedge clk);
      case (k)
        19: chk("i20_no_word_19", wr_en4, 1'b0);
        20: begin
          chk("i20_first_word", wr_en4, 1'b1);
          chk("i20_first_data", data4, 16'h07E0);
          chk("i20_color", cidx4, 3'd1);
        end
        50: chk("i20_no_done_50", done4, 1'b0);
        51: chk("i20_done_51", done4, 1'b1);
        52: begin
          chk("i20_gap_52", wr_en4, 1'b0);
          chk("i20_idle_52", busy4, 1'b0);
        end
        53: chk("i20_b2b_start", wr_en4, 1'b1);
        79: chk("i20_ovr_79", ovr4, 1'b0);
        80: chk("i20_ovr_80", ovr4, 1'b1);
        84: chk("i20_done_84", done4, 1'b1);
        330: chk("i20_ovr_sticky", ovr4, 1'b1);
        default: ;
      endcase
    end
    #1 rst = 1'b1;
    #1;
    chk("i20_ovr_cleared", ovr4, 1'b0);
    init4 = 1'b0;
    @(posedge clk); #1 rst = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
